// File: rtl/g_scan_ctrl.sv
// g_scan_ctrl: rasters signed (m,n) into the fixed-latency G pipeline and streams realigned G samples.
// Optional macro G_SCAN_CONJ_EN adds a conj input that negates g_im (saturating) for back-propagation.
module g_scan_ctrl #(
    parameter int HALF       = 256,
    parameter int LAT        = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        zparam_in,
`ifdef G_SCAN_CONJ_EN
    input  logic               conj,
`endif
    output logic               busy,
    output logic               done,
    output logic signed [9:0]  m_out,
    output logic signed [9:0]  n_out,
    output logic [31:0]        zparam_out,
    input  logic [15:0]        G_re_in,
    input  logic [15:0]        G_im_in,
    output logic               g_valid,
    input  logic               g_ready,
    output logic [15:0]        g_re,
    output logic [15:0]        g_im,
    output logic               g_last
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = CW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic signed [9:0] IDX_MIN = 10'(-HALF);
    localparam logic signed [9:0] IDX_MAX = 10'(HALF - 1);

    logic [1:0]    state, state_nxt;
    logic          issue_c, last_c, push_c, pop_c, credit_c, done_nxt;
    logic [CW-1:0] in_flight, fifo_count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [32:0]   mem [FIFO_DEPTH];
    logic [LAT-1:0] tag_vld, tag_last;
    logic [15:0]   push_im_c;
    logic          head_last;

    // Credit covers both in-flight pipeline samples and FIFO occupancy, so the FIFO cannot overflow.
    always_comb begin
        state_nxt = state;
        issue_c   = 1'b0;
        last_c    = 1'b0;
        done_nxt  = 1'b0;
        push_c    = tag_vld[LAT-1];
        pop_c     = (fifo_count != '0) && g_ready;
        credit_c  = (SW'(in_flight) + SW'(fifo_count)) < SW'(FIFO_DEPTH);
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SCAN;
            end
            S_SCAN: begin
                if (credit_c) begin
                    issue_c = 1'b1;
                    last_c  = (m_out == IDX_MAX) && (n_out == IDX_MAX);
                    if (last_c) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Look ahead one pop so done lands in the cycle right after the last sample leaves.
                if ((in_flight == '0) &&
                    ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop_c))) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            m_out      <= '0;
            n_out      <= '0;
            zparam_out <= '0;
            in_flight  <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            tag_vld    <= '0;
            tag_last   <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
            done  <= done_nxt;

            // Raster: n inner; the final coordinate is held after issue.
            if ((state == S_IDLE) && start) begin
                zparam_out <= zparam_in;
                m_out      <= IDX_MIN;
                n_out      <= IDX_MIN;
            end else if (issue_c && !last_c) begin
                if (n_out == IDX_MAX) begin
                    n_out <= IDX_MIN;
                    m_out <= m_out + 10'sd1;
                end else begin
                    n_out <= n_out + 10'sd1;
                end
            end

            tag_vld[0]  <= issue_c;
            tag_last[0] <= issue_c & last_c;
            for (int i = 1; i < LAT; i++) begin
                tag_vld[i]  <= tag_vld[i-1];
                tag_last[i] <= tag_last[i-1];
            end

            case ({issue_c, push_c})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= in_flight - CW'(1);
                default: in_flight <= in_flight;
            endcase

            case ({push_c, pop_c})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase

            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

`ifdef G_SCAN_CONJ_EN
    logic conj_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           conj_q <= 1'b0;
        else if ((state == S_IDLE) && start) conj_q <= conj;
    end

    // Saturating negate: -(-32768) clips to +32767.
    always_comb begin
        push_im_c = G_im_in;
        if (conj_q) push_im_c = (G_im_in == 16'h8000) ? 16'h7FFF : 16'(16'h0000 - G_im_in);
    end
`else
    always_comb begin
        push_im_c = G_im_in;
    end
`endif

    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr] <= {tag_last[LAT-1], G_re_in, push_im_c};
    end

    assign g_valid = (fifo_count != '0);
    assign {head_last, g_re, g_im} = mem[rd_ptr];
    assign g_last  = g_valid & head_last;

endmodule

// File: tb/tb_g_scan_ctrl.sv
// Bench for g_scan_ctrl: HALF=2 frames against a raster-order reference queue and a delay-line G model.
// Exercises conj saturation when G_SCAN_CONJ_EN is defined.
module tb_g_scan_ctrl;
    localparam int HALF  = 2;
    localparam int LAT   = 5;
    localparam int DEPTH = 8;
    localparam int NS    = 4 * HALF * HALF;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        start     = 1'b0;
    logic [31:0] zparam_in = '0;
    logic        busy, done, g_valid, g_last;
    logic [9:0]  m_out, n_out;
    logic [31:0] zparam_out;
    logic [15:0] G_re_in, G_im_in, g_re, g_im;
    logic        g_ready;
`ifdef G_SCAN_CONJ_EN
    logic        conj_in = 1'b0;
`endif

    g_scan_ctrl #(.HALF(HALF), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .zparam_in(zparam_in),
`ifdef G_SCAN_CONJ_EN
        .conj(conj_in),
`endif
        .busy(busy), .done(done), .m_out(m_out), .n_out(n_out), .zparam_out(zparam_out),
        .G_re_in(G_re_in), .G_im_in(G_im_in), .g_valid(g_valid), .g_ready(g_ready),
        .g_re(g_re), .g_im(g_im), .g_last(g_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // G pipeline model: returns the issued {m,n} packed, LAT cycles later.
    bit          im_force = 1'b0;
    logic [15:0] im_val   = '0;
    bit          conj_exp = 1'b0;
    logic [15:0] gp [LAT];
    always @(posedge clk) begin
        gp[0] <= {m_out[7:0], n_out[7:0]};
        for (int i = 1; i < LAT; i++) gp[i] <= gp[i-1];
    end
    assign G_re_in = gp[LAT-1];
    assign G_im_in = im_force ? im_val : ~gp[LAT-1];

    int ready_mode = 1;
    initial begin
        g_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       g_ready = 1'b0;
                1:       g_ready = 1'b1;
                default: g_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic        last;
    } smp_t;
    smp_t exp_q[$];
    int   got_cnt  = 0;
    int   last_cyc = 0;
    bit   mon_en   = 1'b0;

    function automatic void fill_expected();
        exp_q.delete();
        for (int m = -HALF; m < HALF; m++) begin
            for (int n = -HALF; n < HALF; n++) begin
                smp_t        s;
                logic [15:0] raw_im;
                int          v;
                s.re   = {8'(m), 8'(n)};
                raw_im = im_force ? im_val : ~s.re;
                if (conj_exp) begin
                    v = -int'($signed(raw_im));
                    if (v > 32767) v = 32767;
                    s.im = 16'(v);
                end else begin
                    s.im = raw_im;
                end
                s.last = (m == HALF - 1) && (n == HALF - 1);
                exp_q.push_back(s);
            end
        end
        got_cnt = 0;
    endfunction

    // Stream monitor: order/content on every handshake, and data held while stalled.
    logic [31:0] held;
    bit          hold_chk = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_chk) check("stall_hold", {g_valid, g_re, g_im}, {1'b1, held});
            if (g_valid && g_ready) begin
                check("sample_expected", 64'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    smp_t s;
                    s = exp_q.pop_front();
                    check("g_re", g_re, s.re);
                    check("g_im", g_im, s.im);
                    check("g_last", g_last, s.last);
                end
                if (g_last) last_cyc = cyc;
                got_cnt++;
            end
            hold_chk = g_valid && !g_ready;
            held     = {g_re, g_im};
        end else begin
            hold_chk = 1'b0;
        end
    end

    task automatic pulse_start(input logic [31:0] zp);
        @(negedge clk);
        start     = 1'b1;
        zparam_in = zp;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(output int dones, output int dcyc);
        dones = 0;
        dcyc  = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                dones = 1;
                dcyc  = cyc;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", dones, 1);
    endtask

    task automatic frame_checks(input logic [31:0] zp);
        check("samples", got_cnt, NS);
        check("queue_empty", exp_q.size(), 0);
        check("busy_at_done", busy, 0);
        check("zparam_out", zparam_out, zp);
    endtask

    typedef struct {
        logic [31:0] zp;
        int          mode;
        int          exp_samples;
        int          exp_dones;
    } vec_t;
    vec_t vecs [4];

    initial begin
        int          d, dc;
        logic [31:0] za;
        logic [9:0]  em, en;

        vecs[0] = '{$urandom(), 2, NS, 1};
        vecs[1] = '{$urandom(), 2, NS, 1};
        vecs[2] = '{32'hFFFF_FFFF, 1, NS, 1};
        vecs[3] = '{32'h0000_0001, 2, NS, 1};

        // Reset values
        #1 rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", g_valid, 0);
        check("rst_last", g_last, 0);
        check("rst_m", m_out, 0);
        check("rst_n", n_out, 0);
        check("rst_zparam", zparam_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full-rate frame: consecutive issues, 6-cycle first latency, done right after last
        ready_mode = 1;
        fill_expected();
        mon_en = 1'b1;
        za = 32'h1234_5678;
        pulse_start(za);
        check("busy_scan", busy, 1);
        for (int k = 0; k < NS; k++) begin
            if (k > 0) @(negedge clk);
            em = 10'(-HALF + k / (2 * HALF));
            en = 10'(-HALF + k % (2 * HALF));
            check("m_issue", m_out, em);
            check("n_issue", n_out, en);
            check("first_valid", g_valid, 64'(k >= LAT + 1));
        end
        wait_done(d, dc);
        check("done_after_last", dc, last_cyc + 1);
        frame_checks(za);
        @(negedge clk);
        check("done_pulse", done, 0);

        // Stalled output: credits stop issue at FIFO_DEPTH, then release
        ready_mode = 0;
        fill_expected();
        za = 32'hA5A5_0F0F;
        pulse_start(za);
        repeat (30) @(negedge clk);
        check("stall_m", m_out, 10'd0);
        check("stall_n", n_out, 10'h3FE);
        check("stall_valid", g_valid, 1);
        check("stall_busy", busy, 1);
        repeat (10) @(negedge clk);
        check("frozen_m", m_out, 10'd0);
        check("frozen_n", n_out, 10'h3FE);
        check("stall_none_out", got_cnt, 0);
        ready_mode = 1;
        wait_done(d, dc);
        frame_checks(za);

        // Table of random/full-rate frames
        for (int v = 0; v < 4; v++) begin
            ready_mode = vecs[v].mode;
            fill_expected();
            pulse_start(vecs[v].zp);
            wait_done(d, dc);
            check("vec_dones", d, vecs[v].exp_dones);
            check("vec_samples", got_cnt, vecs[v].exp_samples);
            check("vec_zparam", zparam_out, vecs[v].zp);
            check("vec_busy", busy, 0);
        end

        // start while busy is ignored
        ready_mode = 2;
        fill_expected();
        za = 32'h0BAD_F00D;
        pulse_start(za);
        d = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                d = 1;
                break;
            end
            start     = busy && (i % 3 == 0);
            zparam_in = ~za;
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_done_seen", d, 1);
        frame_checks(za);
        repeat (5) @(negedge clk);
        check("ign_idle", busy, 0);

        // Reset mid-SCAN, then a clean frame
        ready_mode = 1;
        fill_expected();
        pulse_start(32'h7777_1111);
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_valid", g_valid, 0);
        check("mrst_last", g_last, 0);
        check("mrst_m", m_out, 0);
        check("mrst_n", n_out, 0);
        check("mrst_zparam", zparam_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_valid", g_valid, 0);
        fill_expected();
        mon_en = 1'b1;
        za = 32'h3141_5926;
        pulse_start(za);
        wait_done(d, dc);
        frame_checks(za);

`ifdef G_SCAN_CONJ_EN
        // Conjugate output with saturation
        conj_in  = 1'b1;
        conj_exp = 1'b1;
        im_force = 1'b1;
        im_val   = 16'd100;
        fill_expected();
        pulse_start(32'h1);
        wait_done(d, dc);
        frame_checks(32'h1);
        im_val = 16'h8000;
        fill_expected();
        pulse_start(32'h2);
        wait_done(d, dc);
        frame_checks(32'h2);
        conj_in  = 1'b0;
        conj_exp = 1'b0;
        fill_expected();
        pulse_start(32'h3);
        wait_done(d, dc);
        frame_checks(32'h3);
        im_force = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
